// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//
// Brings up a PLL that runs from the same reference clock as this block.
// The sequencer pulses the PLL reset and waits for lock. It then requires
// the lock to stay stable before it releases the system reset. If lock
// does not arrive in time, it retries a bounded number of times. After
// the last failed retry it parks in a fault state. It stays there until
// a restart request or a hard reset arrives.
//
// Ports
//   clk        in   reference clock (also feeds the PLL CLKI)
//   rst        in   asynchronous active-high reset
//   locked     in   PLL LOCK, asynchronous to clk
//   restart    in   single-cycle request to rerun the whole sequence
//   pll_rst    out  active-high PLL reset (S_PLLRST, S_FAULT)
//   sys_rst    out  active-high system reset (low only in S_RUN)
//   ready      out  high only in S_RUN
//   fault      out  high only in S_FAULT
//   retries    out  retries taken since the last S_RUN or restart
//   state_dbg  out  raw FSM state encoding, for debug/checkers
//
// Handshake: restart is a plain level sampled on each rising clk edge.
// There is no acknowledge. A high sample restarts the sequence.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 20000,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          locked,
    input  logic          restart,
    output logic          pll_rst,
    output logic          sys_rst,
    output logic          ready,
    output logic          fault,
    output logic [RW-1:0] retries,
    output logic [2:0]    state_dbg
);

    // The counter is sized for the longest interval it has to measure.
    // Every interval ends at its terminal value, so the counter never wraps.
    localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLLRST = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          locked_m;
    logic          locked_s;

    // Two-flop synchronizer. Only locked_s is used past this point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_PLLRST;
            cnt     <= '0;
            retries <= '0;
        end else if (restart) begin
            // restart overrides every other transition. This includes a
            // restart during S_PLLRST, which begins the pulse count again.
            state   <= S_PLLRST;
            cnt     <= '0;
            retries <= '0;
        end else begin
            case (state)
                S_PLLRST: begin
                    if (cnt == RST_LAST) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (locked_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == WAIT_LAST) begin
                        cnt <= '0;
                        if (retries < RETRY_MAX) begin
                            retries <= retries + 1'b1;
                            state   <= S_PLLRST;
                        end else begin
                            state <= S_FAULT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    // A single unlocked cycle sends the FSM back to S_WAIT.
                    // The timeout window starts again, and no retry is spent.
                    if (!locked_s) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state   <= S_RUN;
                        cnt     <= '0;
                        retries <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state <= S_PLLRST;
                        cnt   <= '0;
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_PLLRST;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Outputs come straight from the state register, with no pipeline
    // delay. So an asynchronous rst shows on the outputs at once.
    assign pll_rst   = (state == S_PLLRST) || (state == S_FAULT);
    assign sys_rst   = (state != S_RUN);
    assign ready     = (state == S_RUN);
    assign fault     = (state == S_FAULT);
    assign state_dbg = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer.
// The DUT is built with RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8
// and MAX_RETRIES=2.
// Inputs change only on the falling clk edge, and outputs are sampled
// there as well. "Cycle k" below means the k-th falling edge after rst
// was released. The state then reflects k rising edges.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [1:0] retries;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail = 0;

  pll_reset_sequencer #(
    .RST_CYCLES(4),
    .LOCK_TIMEOUT(32),
    .STABLE_CYCLES(8),
    .MAX_RETRIES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .locked(locked),
    .restart(restart),
    .pll_rst(pll_rst),
    .sys_rst(sys_rst),
    .ready(ready),
    .fault(fault),
    .retries(retries),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  // Leaves the bench at the falling edge where rst drops ("cycle 0").
  task automatic do_reset();
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Outputs must follow rst before any clock edge arrives.
  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({pll_rst, sys_rst, ready, fault, retries, state_dbg} !== 9'b1100_00_000) begin
      n_fail++;
      $display("FAIL reset_async: got %b want %b",
               {pll_rst, sys_rst, ready, fault, retries, state_dbg}, 9'b1100_00_000);
    end
    for (int k = 0; k < 3; k++) cyc();
    n_checks++;
    if ({pll_rst, sys_rst, ready, fault, retries, state_dbg} !== 9'b1100_00_000) begin
      n_fail++;
      $display("FAIL reset_held: got %b want %b",
               {pll_rst, sys_rst, ready, fault, retries, state_dbg}, 9'b1100_00_000);
    end
  endtask

  // With lock present throughout: pll_rst is high for cycles 1-3,
  // falls at cycle 4, and the FSM reaches run at cycle 13 (9 later).
  task automatic test_lock_normal();
    logic ep, er;
    locked = 1'b1;
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      cyc();
      ep = (k < 4);
      er = (k >= 13);
      n_checks++;
      if ({pll_rst, sys_rst, ready, fault, retries} !== {ep, ~er, er, 1'b0, 2'd0}) begin
        n_fail++;
        $display("FAIL lock_normal c%0d: got %b want %b", k,
                 {pll_rst, sys_rst, ready, fault, retries}, {ep, ~er, er, 1'b0, 2'd0});
      end
    end
  endtask

  // With no lock: pulses at 1-3, 36-39 and 72-75, each followed by a
  // 32-cycle wait. Fault from cycle 108. A restart at 116 then gives a
  // new pulse over 116-119.
  task automatic test_timeout();
    logic ep, ef;
    logic [1:0] eq;
    locked = 1'b0;
    do_reset();
    for (int k = 1; k <= 121; k++) begin
      cyc();
      if (k <= 115) begin
        ep = (k < 4) || (k >= 36 && k < 40) || (k >= 72 && k < 76) || (k >= 108);
        ef = (k >= 108);
        eq = (k >= 72) ? 2'd2 : (k >= 36) ? 2'd1 : 2'd0;
      end else begin
        ep = (k < 120);
        ef = 1'b0;
        eq = 2'd0;
      end
      n_checks++;
      if ({pll_rst, sys_rst, ready, fault, retries} !== {ep, 1'b1, 1'b0, ef, eq}) begin
        n_fail++;
        $display("FAIL timeout c%0d: got %b want %b", k,
                 {pll_rst, sys_rst, ready, fault, retries}, {ep, 1'b1, 1'b0, ef, eq});
      end
      if (k == 115) restart = 1'b1;
      if (k == 116) restart = 1'b0;
    end
  endtask

  // Lock drops for one sampled cycle. The FSM sees it at stable count 5,
  // around rising edge 11. It re-enters stable at edge 12 and runs at 20.
  task automatic test_stable_glitch();
    logic ep, er;
    locked = 1'b1;
    do_reset();
    for (int k = 1; k <= 21; k++) begin
      cyc();
      ep = (k < 4);
      er = (k >= 20);
      n_checks++;
      if ({pll_rst, sys_rst, ready, fault, retries} !== {ep, ~er, er, 1'b0, 2'd0}) begin
        n_fail++;
        $display("FAIL stable_glitch c%0d: got %b want %b", k,
                 {pll_rst, sys_rst, ready, fault, retries}, {ep, ~er, er, 1'b0, 2'd0});
      end
      if (k == 8) locked = 1'b0;
      if (k == 9) locked = 1'b1;
    end
  endtask

  // Starts in run. The unlock takes two sync cycles to arrive, and reset
  // rises at j=3. Relock at j=3 gives pll_rst over 3-6 and run at 16.
  task automatic test_run_unlock();
    logic ep, er;
    locked = 1'b0;
    for (int j = 1; j <= 17; j++) begin
      cyc();
      ep = (j >= 3 && j <= 6);
      er = (j <= 2) || (j >= 16);
      n_checks++;
      if ({pll_rst, sys_rst, ready, fault, retries} !== {ep, ~er, er, 1'b0, 2'd0}) begin
        n_fail++;
        $display("FAIL run_unlock j%0d: got %b want %b", j,
                 {pll_rst, sys_rst, ready, fault, retries}, {ep, ~er, er, 1'b0, 2'd0});
      end
      if (j == 3) locked = 1'b1;
    end
  endtask

  // A restart that coincides with the final timeout (edge 108) wins over
  // the fault. A second restart at edge 110 starts the pulse count again,
  // so the wait begins at 114 rather than 112.
  task automatic test_restart_timeout();
    logic ep;
    logic [1:0] eq;
    locked = 1'b0;
    do_reset();
    for (int k = 1; k <= 115; k++) begin
      cyc();
      ep = (k < 4) || (k >= 36 && k < 40) || (k >= 72 && k < 76) || (k >= 108 && k < 114);
      eq = (k >= 108) ? 2'd0 : (k >= 72) ? 2'd2 : (k >= 36) ? 2'd1 : 2'd0;
      n_checks++;
      if ({pll_rst, sys_rst, ready, fault, retries} !== {ep, 1'b1, 1'b0, 1'b0, eq}) begin
        n_fail++;
        $display("FAIL restart_timeout c%0d: got %b want %b", k,
                 {pll_rst, sys_rst, ready, fault, retries}, {ep, 1'b1, 1'b0, 1'b0, eq});
      end
      if (k == 107) restart = 1'b1;
      if (k == 108) restart = 1'b0;
      if (k == 109) restart = 1'b1;
      if (k == 110) restart = 1'b0;
    end
  endtask

  // rst arrives mid-cycle while in run. The outputs must change before
  // the next rising edge, and the normal sequence must follow on release.
  task automatic test_async_reset();
    logic ep, er;
    locked = 1'b1;
    do_reset();
    for (int k = 1; k <= 14; k++) cyc();
    n_checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL async_pre_run: got %b want %b", {pll_rst, sys_rst, ready}, 3'b001);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({pll_rst, sys_rst, ready, fault, retries} !== 6'b1100_00) begin
      n_fail++;
      $display("FAIL async_reset: got %b want %b",
               {pll_rst, sys_rst, ready, fault, retries}, 6'b1100_00);
    end
    cyc();
    cyc();
    rst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      cyc();
      ep = (k < 4);
      er = (k >= 13);
      n_checks++;
      if ({pll_rst, sys_rst, ready, fault, retries} !== {ep, ~er, er, 1'b0, 2'd0}) begin
        n_fail++;
        $display("FAIL async_restart c%0d: got %b want %b", k,
                 {pll_rst, sys_rst, ready, fault, retries}, {ep, ~er, er, 1'b0, 2'd0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_normal();
    test_timeout();
    test_stable_glitch();
    test_run_unlock();
    test_restart_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
